// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush/freeze enables for a 5-stage pipe, with
// saturating event counters, memory-wait timeout and load-use guard flags.
module pipe_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_timeout,
  output logic             lu_viol
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {RUN, LU, MW} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              do_freeze;
  logic              do_redirect;
  logic              do_stall;
  logic              do_guard;

  // Rule priority: freeze > redirect > stall/guard > normal; rst overrides all.
  always_comb begin
    do_freeze   = dmem_busy;
    do_redirect = !dmem_busy && branch_taken;
    do_stall    = !dmem_busy && !branch_taken && stall_req && (state != LU);
    do_guard    = !dmem_busy && !branch_taken && stall_req && (state == LU);

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    state_nxt    = RUN;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (do_freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_nxt    = MW;
    end else if (do_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (do_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
      state_nxt    = LU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      lu_viol     <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      freeze_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (!dmem_busy) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (dmem_busy && (wait_cnt == WAIT_MAX)) begin
        mem_timeout <= 1'b1;
      end
      if (do_guard) begin
        lu_viol <= 1'b1;
      end

      if (clr_cnt) begin
        stall_cnt  <= '0;
        flush_cnt  <= '0;
        freeze_cnt <= '0;
      end else begin
        if (do_stall && (stall_cnt != '1)) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
        if (do_redirect && (flush_cnt != '1)) begin
          flush_cnt <= flush_cnt + CNT_W'(1);
        end
        if (do_freeze && (freeze_cnt != '1)) begin
          freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W    = 2;
  localparam int unsigned MAX_WAIT = 4;
  localparam int          CMAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             stall_req;
  logic             branch_taken;
  logic             dmem_busy;
  logic             clr_cnt;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic             mem_timeout;
  logic             lu_viol;

  int checks = 0;
  int errors = 0;

  // Reference model: "bubble inserted last cycle", busy run length, counts.
  bit m_bubble;
  int m_run;
  bit m_to;
  bit m_lv;
  int m_stall;
  int m_flush;
  int m_freeze;

  pipe_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .clr_cnt(clr_cnt), .pc_en(pc_en),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .freeze_cnt(freeze_cnt), .mem_timeout(mem_timeout), .lu_viol(lu_viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic do_cycle(input bit r, input bit sr, input bit bt, input bit db, input bit cc);
    logic [6:0] e_ctrl;
    bit stall_ev, guard_ev;
    @(negedge clk);
    rst = r; stall_req = sr; branch_taken = bt; dmem_busy = db; clr_cnt = cc;
    #1;
    stall_ev = !r && !db && !bt && sr && !m_bubble;
    guard_ev = !r && !db && !bt && sr && m_bubble;
    // {pc, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, mem_wb_fl}
    if (r)             e_ctrl = 7'b0000_111;
    else if (db)       e_ctrl = 7'b0000_001;
    else if (bt)       e_ctrl = 7'b1111_110;
    else if (stall_ev) e_ctrl = 7'b0011_010;
    else               e_ctrl = 7'b1111_000;
    chk("ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}, e_ctrl);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("freeze_cnt", freeze_cnt, m_freeze);
    chk("mem_timeout", mem_timeout, m_to);
    chk("lu_viol", lu_viol, m_lv);
    @(posedge clk);
    if (r) begin
      m_bubble = 0; m_run = 0; m_to = 0; m_lv = 0;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      if (db && m_run >= MAX_WAIT) m_to = 1;
      m_run = db ? m_run + 1 : 0;
      if (guard_ev) m_lv = 1;
      m_bubble = stall_ev;
      if (cc) begin
        m_stall = 0; m_flush = 0; m_freeze = 0;
      end else begin
        if (stall_ev)  m_stall  = sat_inc(m_stall);
        if (!db && bt) m_flush  = sat_inc(m_flush);
        if (db)        m_freeze = sat_inc(m_freeze);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(1, 1, 1, 1, 1);
  endtask

  initial begin
    bit pdb;
    rst = 1'b1; stall_req = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0; clr_cnt = 1'b0;
    m_bubble = 0; m_run = 0; m_to = 0; m_lv = 0; m_stall = 0; m_flush = 0; m_freeze = 0;

    // Reset state
    do_reset();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flags", {mem_timeout, lu_viol}, 2'b00);

    // Single load-use stall
    do_cycle(0, 1, 0, 0, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    do_cycle(0, 0, 0, 0, 0);
    chk("lu_after_viol", lu_viol, 0);

    // Held stall -> guard
    do_reset();
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 0);
    chk("held_lu_viol", lu_viol, 1);
    chk("held_stall_cnt", stall_cnt, 1);
    do_cycle(0, 0, 0, 0, 1);
    chk("viol_survives_clr", lu_viol, 1);

    // Branch beats stall
    do_reset();
    do_cycle(0, 1, 1, 0, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);

    // Memory wait with pending branch
    do_reset();
    repeat (3) do_cycle(0, 0, 1, 1, 0);
    do_cycle(0, 0, 1, 0, 0);
    chk("mw_freeze_cnt", freeze_cnt, 3);
    chk("mw_flush_cnt", flush_cnt, 1);

    // Timeout boundary
    do_reset();
    repeat (4) do_cycle(0, 0, 0, 1, 0);
    chk("to_at_max", mem_timeout, 0);
    do_cycle(0, 0, 0, 1, 0);
    chk("to_beyond_max", mem_timeout, 1);
    do_cycle(0, 0, 0, 1, 0);
    repeat (3) do_cycle(0, 0, 0, 0, 1);
    chk("to_sticky", mem_timeout, 1);
    do_reset();
    chk("to_cleared", mem_timeout, 0);

    // Counter saturation and clear priority
    repeat (5) begin
      do_cycle(0, 1, 0, 0, 0);
      do_cycle(0, 0, 0, 0, 0);
    end
    chk("sat_stall_cnt", stall_cnt, 3);
    do_cycle(0, 1, 0, 0, 1);
    chk("clr_stall_cnt", stall_cnt, 0);

    // LU interrupted by freeze, then stall honoured after MW
    do_reset();
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 1, 0, 1, 0);
    do_cycle(0, 1, 0, 0, 0);
    chk("mw_then_stall", stall_cnt, 2);
    chk("mw_no_viol", lu_viol, 0);

    // Reset mid-freeze and mid-stall
    do_cycle(0, 0, 0, 1, 0);
    do_cycle(1, 0, 0, 1, 0);
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(1, 1, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 0);

    // Random traffic
    pdb = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, sr, bt, db, cc;
      r  = ($urandom_range(0, 99) < 2);
      sr = ($urandom_range(0, 99) < 35);
      bt = ($urandom_range(0, 99) < 15);
      db = ($urandom_range(0, 99) < (pdb ? 85 : 15));
      cc = ($urandom_range(0, 99) < 4);
      do_cycle(r, sr, bt, db, cc);
      pdb = db;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
